// File: rtl/dram_arbiter.sv
// Two-port arbiter for a single-outstanding DRAM word port. The winner is latched,
// issued once, and tracked through busy/valid with a timeout before its owner is acked.
module dram_arbiter #(
  parameter int unsigned PRIO_MODE   = 0,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_we,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_we,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        dram_oe,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_we,
  input  logic [31:0] dram_rdata,
  input  logic        dram_valid,
  input  logic        dram_busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        oe_q, wr_q, owner_q, last_q, err_q, ack0_q, ack1_q;
  logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic [3:0]  we_q;
  logic [15:0] cnt_q;

  logic        grant, win, done, tmo;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_we;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    win     = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        grant = calib_done && !dram_busy && (p0_req || p1_req);
        // On contention round-robin favours the port not granted last.
        if (p0_req && p1_req) win = (PRIO_MODE == 1) ? 1'b0 : ~last_q;
        else                  win = !p0_req;
        if (grant) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        done = wr_q ? !dram_busy : dram_valid;
        tmo  = !done && (cnt_q == TMO_LAST);
        if (done || tmo) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;
  assign sel_we    = win ? p1_we    : p0_we;

  // The dram_* output registers double as the latched request; they only load on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= grant;
      ack0_q  <= (done || tmo) && !owner_q;
      ack1_q  <= (done || tmo) && owner_q;
      if (grant) begin
        owner_q <= win;
        last_q  <= win;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wr_q    <= sel_we[0];
        we_q    <= sel_we[0] ? sel_we : 4'b0000;
      end
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 16'd1;
      if (done && !wr_q) begin
        if (owner_q) rdata1_q <= dram_rdata;
        else         rdata0_q <= dram_rdata;
      end
      if (tmo) begin
        err_q <= 1'b1;
        if (owner_q) rdata1_q <= '0;
        else         rdata0_q <= '0;
      end
    end
  end

  assign dram_oe    = oe_q;
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;
  assign dram_we    = we_q;
  assign p0_ack     = ack0_q;
  assign p1_ack     = ack1_q;
  assign p0_rdata   = rdata0_q;
  assign p1_rdata   = rdata1_q;
  assign err        = err_q;
endmodule
